// File: rtl/fp_special_pkg.sv
// rtl/fp_special_pkg.sv - class indices, result codes and default-NaN helper for special-value resolution
package fp_special_pkg;

  localparam int CLS_SNAN = 0;
  localparam int CLS_QNAN = 1;
  localparam int CLS_INF  = 2;
  localparam int CLS_ZERO = 3;
  localparam int CLS_SUB  = 4;
  localparam int CLS_NORM = 5;

  localparam logic [5:0] PT_NONE = 6'b000000;
  localparam logic [5:0] PT_SNAN = 6'b000001;
  localparam logic [5:0] PT_QNAN = 6'b000010;
  localparam logic [5:0] PT_INF  = 6'b000100;
  localparam logic [5:0] PT_ZERO = 6'b001000;
  localparam logic [5:0] PT_PASS = 6'b010000;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_ADD = 1'b1
  } op_e;

  // Right-aligned in 64 bits; callers keep the low 1+exp_w+man_w bits.
  function automatic logic [63:0] default_nan(input logic sign, input int exp_w, input int man_w);
    logic [63:0] v;
    v = 64'(sign) << (exp_w + man_w);
    v = v | (((64'd1 << exp_w) - 64'd1) << man_w);
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/special_value_resolve_comb.sv
// rtl/special_value_resolve_comb.sv - combinational special-value classification and priority for mul/add
module special_value_resolve_comb
  import fp_special_pkg::*;
#(
  parameter int EXP_W      = 5,
  parameter int MAN_W      = 10,
  parameter int QUIET_SNAN = 1,
  parameter int FTZ        = 1
) (
  input  logic                   op,
  input  logic [1:0][4:0]        types,
  input  logic [1:0][EXP_W+MAN_W:0] f,
  output logic [5:0]             p_type,
  output logic [EXP_W+MAN_W:0]   p,
  output logic                   nv_event
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0] QMASK = (QUIET_SNAN != 0) ? (W'(1) << (MAN_W - 1)) : '0;

  logic [1:0]   snan, qnan, inf, zero, sub, sgn;
  logic         sx;
  logic [W-1:0] dnan_sx, dnan_pos, snan_op, qnan_op, inf_op;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      snan[i] = types[i][CLS_SNAN];
      qnan[i] = types[i][CLS_QNAN];
      inf[i]  = types[i][CLS_INF];
      sub[i]  = types[i][CLS_SUB];
      zero[i] = types[i][CLS_ZERO] | (types[i][CLS_SUB] & (FTZ != 0));
      sgn[i]  = f[i][W-1];
    end
  end

  assign sx       = sgn[0] ^ sgn[1];
  assign dnan_sx  = W'(default_nan(sx, EXP_W, MAN_W));
  assign dnan_pos = W'(default_nan(1'b0, EXP_W, MAN_W));
  // Operand 0 takes precedence whenever both qualify.
  assign snan_op  = (snan[0] ? f[0] : f[1]) | QMASK;
  assign qnan_op  = qnan[0] ? f[0] : f[1];
  assign inf_op   = inf[0] ? f[0] : f[1];

  always_comb begin
    p_type   = PT_NONE;
    p        = '0;
    nv_event = 1'b0;
    if (|snan) begin
      p_type   = PT_SNAN;
      p        = snan_op;
      nv_event = 1'b1;
    end else if (op_e'(op) == OP_MUL) begin
      if (|qnan) begin
        p_type = PT_QNAN;
        p      = qnan_op;
      end else if ((inf[0] & zero[1]) | (zero[0] & inf[1])) begin
        p_type   = PT_QNAN;
        p        = dnan_sx;
        nv_event = 1'b1;
      end else if (|inf) begin
        p_type = PT_INF;
        p      = {sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if ((|zero) | (&sub)) begin
        p_type = PT_ZERO;
        p      = {sx, {(W-1){1'b0}}};
      end
    end else begin
      if (|qnan) begin
        p_type = PT_QNAN;
        p      = qnan_op;
      end else if ((&inf) & sx) begin
        p_type   = PT_QNAN;
        p        = dnan_pos;
        nv_event = 1'b1;
      end else if (|inf) begin
        p_type = PT_INF;
        p      = inf_op;
      end else if (&zero) begin
        p_type = PT_ZERO;
        p      = {sgn[0] & sgn[1], {(W-1){1'b0}}};
      end else if (zero[0]) begin
        p_type = PT_PASS;
        p      = f[1];
      end else if (zero[1]) begin
        p_type = PT_PASS;
        p      = f[0];
      end
    end
  end

endmodule

// File: rtl/special_value_resolver_pipe.sv
// rtl/special_value_resolver_pipe.sv - elastic pipeline around the special-value resolver, with sticky invalid flag and counter
module special_value_resolver_pipe
  import fp_special_pkg::*;
#(
  parameter int EXP_W       = 5,
  parameter int MAN_W       = 10,
  parameter int PIPE_STAGES = 2,
  parameter int QUIET_SNAN  = 1,
  parameter int FTZ         = 1,
  parameter int CNT_W       = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      VALID_IN,
  output logic                      READY_IN,
  input  logic                      OP,
  input  logic [1:0][5:0]           TYPES,
  input  logic [1:0][EXP_W+MAN_W:0] F,
  output logic                      VALID_OUT,
  input  logic                      READY_OUT,
  output logic [5:0]                P_TYPE,
  output logic [EXP_W+MAN_W:0]      P,
  output logic                      FLAG_NV,
  output logic [CNT_W-1:0]          NV_CNT,
  input  logic                      FLAG_CLR
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int DW = W + 7;

  logic [5:0]   c_type;
  logic [W-1:0] c_p;
  logic         c_nv;
  logic         out_nv;
  logic         nv_hs;

  special_value_resolve_comb #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .QUIET_SNAN(QUIET_SNAN), .FTZ(FTZ)
  ) u_resolve (
    .op(OP),
    .types({TYPES[1][4:0], TYPES[0][4:0]}),
    .f(F),
    .p_type(c_type),
    .p(c_p),
    .nv_event(c_nv)
  );

  generate
    if (PIPE_STAGES == 0) begin : g_comb
      assign READY_IN  = READY_OUT;
      assign VALID_OUT = VALID_IN;
      assign {out_nv, P_TYPE, P} = {c_nv, c_type, c_p};
    end else begin : g_pipe
      logic [PIPE_STAGES-1:0] vld, ld;
      logic [DW-1:0]          dat [PIPE_STAGES];

      // A stage may load if it or any stage downstream of it is empty, or the output drains.
      always_comb begin
        logic acc;
        ld  = '0;
        acc = READY_OUT;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
          acc   = acc | !vld[k];
          ld[k] = acc;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          vld <= '0;
        end else begin
          if (ld[0]) vld[0] <= VALID_IN;
          for (int k = 1; k < PIPE_STAGES; k++)
            if (ld[k]) vld[k] <= vld[k-1];
        end
      end

      always_ff @(posedge CLK) begin
        if (ld[0]) dat[0] <= {c_nv, c_type, c_p};
        for (int k = 1; k < PIPE_STAGES; k++)
          if (ld[k]) dat[k] <= dat[k-1];
      end

      assign READY_IN  = ld[0];
      assign VALID_OUT = vld[PIPE_STAGES-1];
      // Unreset datapath is masked so an empty pipe always presents zeros.
      assign {out_nv, P_TYPE, P} = vld[PIPE_STAGES-1] ? dat[PIPE_STAGES-1] : '0;
    end
  endgenerate

  assign nv_hs = VALID_OUT & READY_OUT & out_nv;

  always_ff @(posedge CLK) begin
    if (RST) begin
      FLAG_NV <= 1'b0;
      NV_CNT  <= '0;
    end else if (FLAG_CLR) begin
      FLAG_NV <= nv_hs;
      NV_CNT  <= CNT_W'(nv_hs);
    end else if (nv_hs) begin
      FLAG_NV <= 1'b1;
      if (NV_CNT != '1) NV_CNT <= NV_CNT + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && VALID_IN)
      assert ($onehot(TYPES[0]) && $onehot(TYPES[1]));
  end

endmodule

// File: tb/tb_special_value_resolver_pipe.sv
// tb/tb_special_value_resolver_pipe.sv - directed and randomized checks of special_value_resolver_pipe against a value-level model
module tb_special_value_resolver_pipe;

  localparam int K_SNAN = 0, K_QNAN = 1, K_INF = 2, K_ZERO = 3, K_SUB = 4, K_NORM = 5;

  typedef struct packed {
    logic        nv;
    logic [5:0]  t;
    logic [15:0] p;
  } res_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST;

  logic            valid_in, ready_in, op, valid_out, ready_out, flag_nv, flag_clr;
  logic [1:0][5:0] types;
  logic [1:0][15:0] f;
  logic [5:0]      p_type;
  logic [15:0]     p;
  logic [7:0]      nv_cnt;

  logic            v2, r2, op2, vo2, ro2, fnv2, fclr2;
  logic [1:0][5:0] t2;
  logic [1:0][15:0] f2;
  logic [5:0]      pt2;
  logic [15:0]     p2;
  logic [1:0]      cnt2;

  special_value_resolver_pipe dut (
    .CLK(CLK), .RST(RST), .VALID_IN(valid_in), .READY_IN(ready_in), .OP(op), .TYPES(types), .F(f),
    .VALID_OUT(valid_out), .READY_OUT(ready_out), .P_TYPE(p_type), .P(p), .FLAG_NV(flag_nv),
    .NV_CNT(nv_cnt), .FLAG_CLR(flag_clr)
  );

  special_value_resolver_pipe #(.PIPE_STAGES(0), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .VALID_IN(v2), .READY_IN(r2), .OP(op2), .TYPES(t2), .F(f2),
    .VALID_OUT(vo2), .READY_OUT(ro2), .P_TYPE(pt2), .P(p2), .FLAG_NV(fnv2),
    .NV_CNT(cnt2), .FLAG_CLR(fclr2)
  );

  int   n_cmp = 0, n_bad = 0;
  res_t exp_q[$];
  logic mflag = 1'b0;
  int   mcnt = 0;
  logic held = 1'b0, saw_stall_in = 1'b0, rand_done = 1'b0, m_ev;
  logic [15:0] held_p, r_a, r_b;
  logic [5:0]  held_t;
  logic r_add;
  res_t m_e;
  int   n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic nv, input logic [5:0] t, input logic [15:0] v);
    res_t r;
    r.nv = nv; r.t = t; r.p = v;
    return r;
  endfunction

  function automatic int cls_of(input logic [15:0] x);
    if (x[14:10] == 5'h1f) return (x[9:0] == 10'h0) ? K_INF : (x[9] ? K_QNAN : K_SNAN);
    if (x[14:10] == 5'h00) return (x[9:0] == 10'h0) ? K_ZERO : K_SUB;
    return K_NORM;
  endfunction

  function automatic logic [5:0] oh(input int c);
    return 6'd1 << c;
  endfunction

  // Value-level reference for half precision with QUIET_SNAN=1 and FTZ=1.
  function automatic res_t model(input logic is_add, input logic [15:0] a, input logic [15:0] b);
    int ca, cb;
    logic za, zb, sx;
    ca = cls_of(a); cb = cls_of(b);
    za = (ca == K_ZERO) || (ca == K_SUB);
    zb = (cb == K_ZERO) || (cb == K_SUB);
    sx = a[15] ^ b[15];
    if (ca == K_SNAN || cb == K_SNAN) return mk(1, 6'd1, ((ca == K_SNAN) ? a : b) | 16'h0200);
    if (ca == K_QNAN || cb == K_QNAN) return mk(0, 6'd2, (ca == K_QNAN) ? a : b);
    if (!is_add && ((ca == K_INF && zb) || (za && cb == K_INF))) return mk(1, 6'd2, {sx, 15'h7e00});
    if (is_add && ca == K_INF && cb == K_INF && a[15] != b[15]) return mk(1, 6'd2, 16'h7e00);
    if (ca == K_INF || cb == K_INF)
      return mk(0, 6'd4, is_add ? ((ca == K_INF) ? a : b) : {sx, 15'h7c00});
    if (!is_add && (za || zb)) return mk(0, 6'd8, {sx, 15'h0});
    if (is_add && za && zb) return mk(0, 6'd8, {a[15] & b[15], 15'h0});
    if (is_add && (za || zb)) return mk(0, 6'd16, za ? b : a);
    return mk(0, 6'd0, 16'h0);
  endfunction

  function automatic logic [15:0] rand_val(input int c);
    logic [15:0] x;
    x[15] = 1'($urandom_range(0, 1));
    case (c)
      K_SNAN:  x[14:0] = {5'h1f, 1'b0, 9'($urandom_range(1, 511))};
      K_QNAN:  x[14:0] = {5'h1f, 1'b1, 9'($urandom)};
      K_INF:   x[14:0] = {5'h1f, 10'h0};
      K_ZERO:  x[14:0] = 15'h0;
      K_SUB:   x[14:0] = {5'h0, 10'($urandom_range(1, 1023))};
      default: x[14:0] = {5'($urandom_range(1, 30)), 10'($urandom)};
    endcase
    return x;
  endfunction

  task automatic send(input logic is_add, input logic [15:0] a, input logic [15:0] b, input res_t e);
    int k;
    logic ok;
    op = is_add; f[0] = a; f[1] = b;
    types[0] = oh(cls_of(a)); types[1] = oh(cls_of(b));
    valid_in = 1'b1;
    k = 0; ok = 1'b0;
    while (!ok && k < 200) begin
      @(negedge CLK);
      ok = ready_in;
      k++;
    end
    if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
    else exp_q.push_back(e);
    @(posedge CLK); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge CLK);
      k++;
    end
    #1;
    check_eq(tag, exp_q.size(), 32'd0);
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      mflag = 1'b0; mcnt = 0; held = 1'b0;
    end else begin
      check_eq("flag_nv", flag_nv, mflag);
      check_eq("nv_cnt", nv_cnt, mcnt);
      if (valid_in && !ready_in) saw_stall_in = 1'b1;
      m_ev = 1'b0;
      if (valid_out) begin
        if (held) begin
          check_eq("stall_p", p, held_p);
          check_eq("stall_t", p_type, held_t);
        end
        if (ready_out) begin
          held = 1'b0;
          if (exp_q.size() == 0) check_eq("extra_out", 32'd1, 32'd0);
          else begin
            m_e = exp_q.pop_front();
            check_eq("out_p", p, m_e.p);
            check_eq("out_t", p_type, m_e.t);
            m_ev = m_e.nv;
          end
        end else begin
          held = 1'b1; held_p = p; held_t = p_type;
        end
      end else held = 1'b0;
      if (flag_clr) begin
        mflag = m_ev; mcnt = m_ev ? 1 : 0;
      end else if (m_ev) begin
        mflag = 1'b1;
        if (mcnt < 255) mcnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal;
  end

  initial begin
    RST = 1'b1; valid_in = 1'b0; op = 1'b0; f = '0; types = {6'b100000, 6'b100000};
    ready_out = 1'b1; flag_clr = 1'b0;
    v2 = 1'b0; op2 = 1'b0; f2 = '0; t2 = {6'b100000, 6'b100000}; ro2 = 1'b1; fclr2 = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    check_eq("rst_valid_out", valid_out, 32'd0);
    check_eq("rst_p", p, 32'd0);
    check_eq("rst_p_type", p_type, 32'd0);
    check_eq("rst_ready_in", ready_in, 32'd1);
    check_eq("rst_cnt2", cnt2, 32'd0);

    // sNaN multiply: two-cycle latency, quieted payload, flag/counter update
    send(0, 16'h7d00, 16'h3c00, mk(1, 6'd1, 16'h7f00));
    check_eq("lat1_valid", valid_out, 32'd0);
    @(posedge CLK); #1;
    check_eq("lat2_valid", valid_out, 32'd1);
    check_eq("lat2_p", p, 32'h7f00);
    check_eq("lat2_t", p_type, 32'd1);
    @(posedge CLK); #1;
    check_eq("snan_flag", flag_nv, 32'd1);
    check_eq("snan_cnt", nv_cnt, 32'd1);

    send(0, 16'hfc00, 16'h0000, mk(1, 6'd2, 16'hfe00));
    send(0, 16'hfc00, 16'h3c00, mk(0, 6'd4, 16'hfc00));
    send(1, 16'h7c00, 16'hfc00, mk(1, 6'd2, 16'h7e00));
    send(1, 16'h8000, 16'h4200, mk(0, 6'd16, 16'h4200));
    send(1, 16'h8000, 16'h8000, mk(0, 6'd8, 16'h8000));
    send(1, 16'h0000, 16'h8000, mk(0, 6'd8, 16'h0000));
    send(0, 16'h0001, 16'h8002, mk(0, 6'd8, 16'h8000));
    send(1, 16'h0001, 16'h3c00, mk(0, 6'd16, 16'h3c00));
    wait_drain("directed_drain");
    check_eq("directed_cnt", nv_cnt, 32'd3);

    // Backpressure: six passthrough ops, output stalled for cycles 3-5
    saw_stall_in = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(1, 16'h3c00 + 16'(i), 16'h0000, mk(0, 6'd16, 16'h3c00 + 16'(i)));
      end
      begin
        repeat (2) @(posedge CLK);
        #1 ready_out = 1'b0;
        repeat (3) @(posedge CLK);
        #1 ready_out = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check_eq("bp_ready_in_dropped", saw_stall_in, 32'd1);

    // FLAG_CLR coinciding with an invalid handshake, then FLAG_CLR alone
    send(0, 16'h7c00, 16'h0000, mk(1, 6'd2, 16'h7e00));
    n = 0;
    while (!valid_out && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check_eq("clr_wait_valid", valid_out, 32'd1);
    flag_clr = 1'b1;
    @(posedge CLK); #1;
    flag_clr = 1'b0;
    check_eq("clr_nv_flag", flag_nv, 32'd1);
    check_eq("clr_nv_cnt", nv_cnt, 32'd1);
    flag_clr = 1'b1;
    @(posedge CLK); #1;
    flag_clr = 1'b0;
    check_eq("clr_only_flag", flag_nv, 32'd0);
    check_eq("clr_only_cnt", nv_cnt, 32'd0);

    // Randomized operands with random READY_OUT and occasional FLAG_CLR
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          r_add = 1'($urandom_range(0, 1));
          r_a = rand_val(int'($urandom_range(0, 5)));
          r_b = rand_val(int'($urandom_range(0, 5)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK); #1;
          end
          send(r_add, r_a, r_b, model(r_add, r_a, r_b));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge CLK); #1;
          ready_out = ($urandom_range(0, 9) < 7);
          flag_clr  = ($urandom_range(0, 49) == 0);
        end
        ready_out = 1'b1;
        flag_clr  = 1'b0;
      end
    join
    wait_drain("rand_drain");

    // Combinational instance with a 2-bit saturating counter
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin op2 = 0; f2[0] = 16'h7c00; f2[1] = 16'h0000; end
        1: begin op2 = 1; f2[0] = 16'h7c00; f2[1] = 16'hfc00; end
        2: begin op2 = 0; f2[0] = 16'h7d00; f2[1] = 16'h3c00; end
        3: begin op2 = 1; f2[0] = 16'h3c00; f2[1] = 16'hfd01; end
        default: begin op2 = 0; f2[0] = 16'h0000; f2[1] = 16'hfc00; end
      endcase
      t2[0] = oh(cls_of(f2[0])); t2[1] = oh(cls_of(f2[1]));
      v2 = 1'b1; ro2 = 1'b1;
      #2;
      m_e = model(op2, f2[0], f2[1]);
      check_eq("c0_ready_in", r2, 32'd1);
      check_eq("c0_valid_out", vo2, 32'd1);
      check_eq("c0_p", p2, m_e.p);
      check_eq("c0_t", pt2, m_e.t);
      check_eq("c0_cnt_before", cnt2, (i < 3) ? i : 3);
      @(posedge CLK); #1;
    end
    check_eq("c0_cnt_sat", cnt2, 32'd3);
    check_eq("c0_flag", fnv2, 32'd1);
    v2 = 1'b0; ro2 = 1'b0;
    #1;
    check_eq("c0_ready_follow", r2, 32'd0);
    check_eq("c0_valid_follow", vo2, 32'd0);

    // Reset with data in flight
    @(posedge CLK); #1;
    ready_out = 1'b0;
    send(0, 16'h7d00, 16'h3c00, mk(1, 6'd1, 16'h7f00));
    send(1, 16'h3c00, 16'h0000, mk(0, 6'd16, 16'h3c00));
    check_eq("mid_valid_before", valid_out, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_eq("mid_valid_out", valid_out, 32'd0);
    check_eq("mid_nv_cnt", nv_cnt, 32'd0);
    check_eq("mid_flag", flag_nv, 32'd0);
    check_eq("mid_p", p, 32'd0);
    check_eq("mid_p_type", p_type, 32'd0);
    check_eq("mid_cnt2", cnt2, 32'd0);
    ready_out = 1'b1;
    repeat (5) begin
      @(posedge CLK); #1;
      check_eq("mid_no_stale", valid_out, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/special_value_resolver_pipe.md
Name: special_value_resolver_pipe

Overview:
- Parametrised, pipelined successor of the float16 extreme-value detection stage in the MAC systolic array.
- Resolves IEEE-754 special-value results (NaN, inf, zero, passthrough) for both multiply and add operations.
- Works for any exponent/mantissa width, through an elastic valid/ready pipeline.
- Keeps a sticky invalid-operation flag and a saturating invalid-event counter for the PE status register.

Parameters:
- EXP_W, 5, exponent width; W = 1+EXP_W+MAN_W.
- MAN_W, 10, mantissa width.
- PIPE_STAGES, 2, register stages 0..3; 0 = combinational pass-through.
- QUIET_SNAN, 1, when 1, sNaN payloads are output with the mantissa MSB set.
- FTZ, 1, when 1, subnormal operands are treated as signed zero.
- CNT_W, 8, width of the invalid-event counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- VALID_IN  in  1  operand pair valid.
- READY_IN  out  1  block can accept the operand pair.
- OP  in  1  0 = multiply, 1 = add.
- TYPES  in  [1:0][5:0]  per-operand one-hot class: 5 normal, 4 subnormal, 3 zero, 2 inf, 1 qNaN, 0 sNaN.
- F  in  [1:0][W-1:0]  operands.
- VALID_OUT  out  1  result valid.
- READY_OUT  in  1  downstream accepts the result.
- P_TYPE  out  6  result code: 000001 sNaN, 000010 qNaN/invalid, 000100 inf, 001000 zero, 010000 passthrough, 000000 not special (normal datapath computes).
- P  out  W  resolved value.
- FLAG_NV  out  1  sticky invalid flag.
- NV_CNT  out  CNT_W  saturating count of invalid results.
- FLAG_CLR  in  1  clears FLAG_NV and NV_CNT.

Behaviour:
- Definitions: dNaN(s) = {s, all-ones exponent, mantissa MSB 1, rest 0}; sx = F[0] sign XOR F[1] sign.
- Operand priority: operand 0 wins whenever both operands qualify.
- Multiply priority, first match wins:
  - sNaN present: P = that operand, quieted if QUIET_SNAN; code 000001.
  - qNaN present, or inf×zero: code 000010. P = dNaN(sx) for inf×zero; otherwise the qNaN operand.
  - inf present: P = {sx, all-ones exp, 0}; code 000100.
  - Zero present, or both subnormal: P = {sx, 0}; code 001000. With FTZ=1, any subnormal counts as zero.
  - Otherwise: code 000000, P = 0.
- Add priority, first match wins:
  - sNaN: same as multiply.
  - qNaN present, or inf of opposite signs: code 000010. P = dNaN(0) for inf-inf; otherwise the qNaN operand.
  - inf present: P = the first inf operand; code 000100.
  - Both zero (after FTZ): P = {s0 & s1, 0}; code 001000.
  - Exactly one zero: P = the other operand; code 010000.
  - Otherwise: 000000, P = 0.
- Invalid events: sNaN result, inf×zero, inf-inf.
- Pipeline:
  - Stage k loads when it is empty, or when its content moves to stage k+1 (or out) in the same cycle.
  - READY_IN = stage 0 can load. Bubbles collapse; order is preserved.
  - No loss or duplication under any READY_OUT pattern.
  - Latency is PIPE_STAGES cycles with READY_OUT held high; full throughput of 1 per cycle.
  - PIPE_STAGES = 0: READY_IN = READY_OUT, VALID_OUT = VALID_IN, outputs combinational.
  - P/P_TYPE hold stable while VALID_OUT=1 and READY_OUT=0.
- Flags and counter:
  - Updated only on an output handshake (VALID_OUT & READY_OUT) carrying an invalid event.
  - FLAG_NV is set; NV_CNT increments and saturates at 2^CNT_W-1.
  - FLAG_CLR alone: both go to 0 next cycle.
  - FLAG_CLR with a simultaneous invalid handshake: FLAG_NV=1, NV_CNT=1.
- Reset, including mid-stream: all stage valids, VALID_OUT, FLAG_NV and NV_CNT go to 0. Datapath registers are not reset; P and P_TYPE are 0 after reset. In-flight data is discarded.
- Invalid TYPES input (not one-hot) is undefined; an assertion flags it in simulation.

Decomposition:
- Package fp_special_pkg holds:
  - class bit index localparams;
  - P_TYPE code constants;
  - function default_nan(sign, EXP_W, MAN_W);
  - the op_e enum (OP_MUL, OP_ADD).
- Sub-module special_value_resolve_comb: purely combinational classification and priority, parametrised by EXP_W, MAN_W, QUIET_SNAN, FTZ. It outputs p_type, p and nv_event, and sits in front of stage 0.
- The top level owns the elastic pipeline, flags and counter.

Test Plan:
- Multiply, PIPE_STAGES=2: F0=0x7D00 sNaN, F1=0x3C00 normal -> after 2 cycles P=0x7F00, P_TYPE=000001; FLAG_NV=1, NV_CNT=1.
- Multiply: F0=0xFC00 (-inf), F1=0x0000 -> P=0xFE00, P_TYPE=000010, NV_CNT increments. Then 0xFC00 × 0x3C00 -> P=0xFC00, 000100.
- Add: 0x7C00 + 0xFC00 -> P=0x7E00, 000010. Then 0x8000 + 0x4200 -> P=0x4200, 010000; 0x8000 + 0x8000 -> 0x8000; 0x0000 + 0x8000 -> 0x0000, 001000.
- FTZ=1: two subnormals (0x0001 × 0x8002) -> P=0x8000, 001000. Add 0x0001 + 0x3C00 -> passthrough 0x3C00.
- Backpressure: 6 back-to-back ops with READY_OUT low for cycles 3-5 -> READY_IN deasserts once both stages are full; the outputs are exactly the 6 ops in order; P stays stable while stalled.
- FLAG_CLR in the same cycle as an invalid handshake -> FLAG_NV=1, NV_CNT=1.
- CNT_W=2 with 5 invalid ops -> NV_CNT=3.
- RST mid-stream -> VALID_OUT=0 and NV_CNT=0 next cycle, with no stale result afterwards.
